life_rule_pipeline: RTL and testbench

Next-generation evaluator for the banked Conway frame buffer. It sits directly downstream of the pixel/block address sequencer, which issues per-cycle read enables, a one-hot centre bank, a write address and the frame-buffer select. It also receives the 9 bank read-data bits. It aligns the sequencer's control with memory read latency, counts the live in-bounds neighbours of the centre pixel, applies the B3/S23 rule, and drives the write port of the inactive frame buffer. It also reports per-frame population and a generation count.

---
 rtl/conway_pkg.sv | 35 +++
 rtl/pipe_delay.sv | 38 +++
 rtl/life_rule_pipeline.sv | 128 ++++++++++++
 tb/tb_life_rule_pipeline.sv | 320 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/conway_pkg.sv
// Shared constants, the per-stage control bundle and small helpers for the
// Conway next-generation pipeline.
package conway_pkg;

    localparam int BANKS       = 9;
    localparam int COUNT_WIDTH = 4;
    localparam int BIRTH_COUNT = 3;
    localparam int SURVIVE_MIN = 2;
    localparam int SURVIVE_MAX = 3;

    // Control captured from the sequencer and carried alongside the memory read.
    typedef struct packed {
        logic             valid;
        logic             first;
        logic             sel;
        logic [BANKS-1:0] we;
        logic [BANKS-1:0] re;
    } stage_ctrl_t;

    // Bank holding pixel offset (px, py) inside a 3x3 block.
    function automatic logic [3:0] bank_index(input logic [1:0] px, input logic [1:0] py);
        return 4'(3 * int'(py) + int'(px));
    endfunction

    // Number of set bits across the nine bank lanes.
    function automatic logic [COUNT_WIDTH-1:0] popcount_banks(input logic [BANKS-1:0] v);
        logic [COUNT_WIDTH-1:0] n;
        n = '0;
        for (int i = 0; i < BANKS; i++) begin
            n = n + COUNT_WIDTH'(v[i]);
        end
        return n;
    endfunction

endpackage

// File: rtl/pipe_delay.sv
// Fixed-depth shift register with synchronous clear; DEPTH=0 is a straight wire.
module pipe_delay #(
    parameter int WIDTH = 1,
    parameter int DEPTH = 1
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic [WIDTH-1:0] d_i,
    output logic [WIDTH-1:0] q_o
);

    generate
        if (DEPTH == 0) begin : g_pass
            logic unused_pass;
            assign unused_pass = clk ^ resetn;
            assign q_o = d_i;
        end else begin : g_shift
            logic [WIDTH-1:0] stage_q [DEPTH];

            // Shift one slot per cycle; clear every slot on reset.
            always_ff @(posedge clk) begin
                if (!resetn) begin
                    for (int i = 0; i < DEPTH; i++) begin
                        stage_q[i] <= '0;
                    end
                end else begin
                    stage_q[0] <= d_i;
                    for (int i = 1; i < DEPTH; i++) begin
                        stage_q[i] <= stage_q[i-1];
                    end
                end
            end

            assign q_o = stage_q[DEPTH-1];
        end
    endgenerate

endmodule

// File: rtl/life_rule_pipeline.sv
// Next-generation evaluator: aligns sequencer control with bank read data,
// applies B3/S23 to the centre pixel and writes the inactive frame buffer,
// while tracking per-frame population and generation count.
//
// Handshake: enable is a valid with no ready. Every cycle with enable=1 is one
// pixel that is consumed unconditionally; the pipeline never stalls, and
// enable=0 cycles travel as bubbles that produce no write.
import conway_pkg::*;

module life_rule_pipeline #(
    parameter int ADDR_WIDTH   = 2,
    parameter int READ_LATENCY = 1,
    parameter int POP_WIDTH    = 16,
    parameter int GEN_WIDTH    = 16
) (
    input  logic                  clk,
    input  logic                  resetn,
    input  logic                  enable,
    input  logic [BANKS-1:0]      write_enable_in,
    input  logic [BANKS-1:0]      read_enable_in,
    input  logic [ADDR_WIDTH-1:0] write_addr_in,
    input  logic                  frame_buffer_select_in,
    input  logic [BANKS-1:0]      read_data,
    output logic [BANKS-1:0]      mem_write_enable,
    output logic [ADDR_WIDTH-1:0] mem_write_addr,
    output logic                  mem_write_data,
    output logic                  mem_write_buffer,
    output logic                  frame_done,
    output logic [POP_WIDTH-1:0]  population,
    output logic [GEN_WIDTH-1:0]  generation,
    output logic                  onehot_error
);

    localparam int ALIGN_W = $bits(stage_ctrl_t) + ADDR_WIDTH;

    stage_ctrl_t           s0_q;
    logic [ADDR_WIDTH-1:0] s0_addr_q;
    logic                  last_sel_q;

    logic [ALIGN_W-1:0]    al_vec;
    stage_ctrl_t           al_ctrl;
    logic [ADDR_WIDTH-1:0] al_addr;

    logic                  centre;
    logic [COUNT_WIDTH-1:0] live_count;
    logic                  next_state;
    logic                  we_onehot;
    logic                  write_issue;

    logic [POP_WIDTH-1:0]  acc_q;

    // Stage 0: capture sequencer control; a select change marks a frame's first pixel.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            s0_q       <= '0;
            s0_addr_q  <= '0;
            last_sel_q <= 1'b1;
        end else begin
            s0_q.valid <= enable;
            if (enable) begin
                s0_q.we    <= write_enable_in;
                s0_q.re    <= read_enable_in;
                s0_q.sel   <= frame_buffer_select_in;
                s0_q.first <= (frame_buffer_select_in != last_sel_q);
                s0_addr_q  <= write_addr_in;
                last_sel_q <= frame_buffer_select_in;
            end
        end
    end

    // Remaining read latency so the bundle meets its bank data.
    pipe_delay #(
        .WIDTH(ALIGN_W),
        .DEPTH(READ_LATENCY - 1)
    ) u_align (
        .clk   (clk),
        .resetn(resetn),
        .d_i   ({s0_q, s0_addr_q}),
        .q_o   (al_vec)
    );

    assign {al_ctrl, al_addr} = al_vec;

    // Neighbour count excludes the centre lane and any out-of-grid lane.
    assign centre      = |(read_data & al_ctrl.we);
    assign live_count  = popcount_banks(read_data & al_ctrl.re & ~al_ctrl.we);
    assign next_state  = (live_count == COUNT_WIDTH'(BIRTH_COUNT)) ||
                         (centre && (live_count >= COUNT_WIDTH'(SURVIVE_MIN)) &&
                                    (live_count <= COUNT_WIDTH'(SURVIVE_MAX)));
    assign we_onehot   = (popcount_banks(al_ctrl.we) == COUNT_WIDTH'(1));
    assign write_issue = al_ctrl.valid && we_onehot;

    // Output register: write strobe, frame bookkeeping and sticky one-hot error.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            mem_write_enable <= '0;
            mem_write_addr   <= '0;
            mem_write_data   <= 1'b0;
            mem_write_buffer <= 1'b0;
            frame_done       <= 1'b0;
            population       <= '0;
            generation       <= '0;
            onehot_error     <= 1'b0;
            acc_q            <= '0;
        end else begin
            mem_write_enable <= '0;
            frame_done       <= 1'b0;
            if (write_issue) begin
                mem_write_enable <= al_ctrl.we;
                mem_write_addr   <= al_addr;
                mem_write_data   <= next_state;
                mem_write_buffer <= ~al_ctrl.sel;
            end
            if (al_ctrl.valid && !we_onehot) begin
                onehot_error <= 1'b1;
            end
            if (al_ctrl.valid && al_ctrl.first) begin
                population <= acc_q;
                acc_q      <= {{(POP_WIDTH-1){1'b0}}, write_issue && next_state};
                generation <= generation + GEN_WIDTH'(1);
                frame_done <= 1'b1;
            end else if (write_issue && next_state && (acc_q != {POP_WIDTH{1'b1}})) begin
                acc_q <= acc_q + POP_WIDTH'(1);
            end
        end
    end

endmodule

// File: tb/tb_life_rule_pipeline.sv
// Bench for life_rule_pipeline: grid-level reference model, directed rule
// vectors, bubbles, one-hot error and mid-pipeline reset.
`timescale 1ns/1ps
module tb_life_rule_pipeline;

    localparam int AW   = 2;
    localparam int RL   = 1;
    localparam int PW   = 16;
    localparam int GW   = 16;
    localparam int WR_W = 32 + 9 + AW + 2;
    localparam int FR_W = 32 + PW + GW;

    logic          clk = 1'b0;
    logic          resetn;
    logic          enable;
    logic [8:0]    write_enable_in;
    logic [8:0]    read_enable_in;
    logic [AW-1:0] write_addr_in;
    logic          frame_buffer_select_in;
    logic [8:0]    read_data;
    logic [8:0]    mem_write_enable;
    logic [AW-1:0] mem_write_addr;
    logic          mem_write_data;
    logic          mem_write_buffer;
    logic          frame_done;
    logic [PW-1:0] population;
    logic [GW-1:0] generation;
    logic          onehot_error;

    life_rule_pipeline #(
        .ADDR_WIDTH(AW), .READ_LATENCY(RL), .POP_WIDTH(PW), .GEN_WIDTH(GW)
    ) dut (
        .clk                   (clk),
        .resetn                (resetn),
        .enable                (enable),
        .write_enable_in       (write_enable_in),
        .read_enable_in        (read_enable_in),
        .write_addr_in         (write_addr_in),
        .frame_buffer_select_in(frame_buffer_select_in),
        .read_data             (read_data),
        .mem_write_enable      (mem_write_enable),
        .mem_write_addr        (mem_write_addr),
        .mem_write_data        (mem_write_data),
        .mem_write_buffer      (mem_write_buffer),
        .frame_done            (frame_done),
        .population            (population),
        .generation            (generation),
        .onehot_error          (onehot_error)
    );

    // ---------------- clock ----------------
    always #5 clk = ~clk;

    // ---------------- scoreboard state ----------------
    int checks  = 0;
    int errors  = 0;
    int neg_cnt = 0;
    logic [WR_W-1:0] exp_q[$];
    logic [FR_W-1:0] frm_q[$];
    logic [8:0]      rd_q[$];
    bit              err_exp;
    int              err_due;

    // reference model state
    bit last_sel;
    int acc;
    int gen;
    bit grid [0:5][0:5];
    bit nxt  [0:5][0:5];

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", name, got, exp);
        end
    endtask

    task automatic model_reset();
        last_sel = 1'b1;
        acc      = 0;
        gen      = 0;
        err_exp  = 1'b0;
        err_due  = 0;
        exp_q.delete();
        frm_q.delete();
        rd_q.delete();
        for (int i = 0; i < RL; i++) rd_q.push_back(9'h0);
    endtask

    // ---------------- driver ----------------
    // Drives one cycle; read data for this pixel appears RL cycles later.
    task automatic drive(input bit en, input logic [8:0] we, input logic [8:0] re,
                         input logic [AW-1:0] addr, input bit sel, input logic [8:0] rd,
                         input bit exp_data);
        int due;
        bit first;
        bit oh;
        @(posedge clk);
        #1;
        enable                 = en;
        write_enable_in        = we;
        read_enable_in         = re;
        write_addr_in          = addr;
        frame_buffer_select_in = sel;
        rd_q.push_back(rd);
        read_data = rd_q.pop_front();
        if (en) begin
            due      = neg_cnt + RL + 1;
            first    = (sel != last_sel);
            last_sel = sel;
            oh       = ($countones(we) == 1);
            if (first) begin
                frm_q.push_back({32'(due), PW'(acc), GW'(gen + 1)});
                gen++;
                acc = (oh && exp_data) ? 1 : 0;
            end else if (oh && exp_data && acc < (1 << PW) - 1) begin
                acc++;
            end
            if (oh) exp_q.push_back({32'(due), we, addr, exp_data, ~sel});
            else if (!err_exp) begin
                err_exp = 1'b1;
                err_due = due;
            end
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(1'b0, 9'h0, 9'h0, '0, 1'b0, 9'h0, 1'b0);
    endtask

    task automatic bubble();
        drive(1'b0, 9'($urandom), 9'($urandom), AW'($urandom), 1'($urandom), 9'($urandom), 1'b0);
    endtask

    // One grid pixel: bank lanes built from the 6x6 grid, expected state from
    // a direct neighbour count on the grid.
    task automatic grid_pixel(input int x, input int y, input bit sel);
        logic [8:0] we, re, rd;
        int cnt, xx, yy, b;
        bit ns;
        we = 9'h0; re = 9'h0; rd = 9'($urandom); cnt = 0;
        for (int dy = -1; dy <= 1; dy++) begin
            for (int dx = -1; dx <= 1; dx++) begin
                xx = x + dx; yy = y + dy;
                b  = 3 * ((yy + 3) % 3) + ((xx + 3) % 3);
                if (xx >= 0 && xx < 6 && yy >= 0 && yy < 6) begin
                    re[b] = 1'b1;
                    rd[b] = grid[yy][xx];
                    if (dx == 0 && dy == 0) we[b] = 1'b1;
                    else cnt += int'(grid[yy][xx]);
                end
            end
        end
        ns = (cnt == 3) || (grid[y][x] && cnt == 2);
        nxt[y][x] = ns;
        drive(1'b1, we, re, AW'((y / 3) * 2 + x / 3), sel, rd, ns);
    endtask

    task automatic run_frame(input bit sel);
        for (int y = 0; y < 6; y++) begin
            for (int x = 0; x < 6; x++) begin
                if ($urandom_range(0, 3) == 0) bubble();
                grid_pixel(x, y, sel);
            end
        end
        for (int y = 0; y < 6; y++)
            for (int x = 0; x < 6; x++) grid[y][x] = nxt[y][x];
    endtask

    task automatic apply_reset();
        @(posedge clk);
        #1;
        resetn = 1'b0;
        enable = 1'b0;
        read_data = 9'h0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        resetn = 1'b1;
        @(negedge clk);
        check("rst_we",   32'(mem_write_enable), 32'h0);
        check("rst_addr", 32'(mem_write_addr),   32'h0);
        check("rst_data", 32'(mem_write_data),   32'h0);
        check("rst_buf",  32'(mem_write_buffer), 32'h0);
        check("rst_fd",   32'(frame_done),       32'h0);
        check("rst_pop",  32'(population),       32'h0);
        check("rst_gen",  32'(generation),       32'h0);
        check("rst_err",  32'(onehot_error),     32'h0);
    endtask

    // ---------------- monitor ----------------
    always @(negedge clk) begin
        logic [WR_W-1:0] e;
        logic [FR_W-1:0] f;
        if (mem_write_enable != 9'h0) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL write_unexpected cyc=%0d we=%h", neg_cnt, mem_write_enable);
            end else begin
                e = exp_q[0];
                if (int'(e[WR_W-1 -: 32]) != neg_cnt) begin
                    errors++;
                    $display("FAIL write_timing cyc=%0d due=%0d", neg_cnt, int'(e[WR_W-1 -: 32]));
                end else begin
                    void'(exp_q.pop_front());
                    if ({mem_write_enable, mem_write_addr, mem_write_data, mem_write_buffer} !== e[WR_W-33:0]) begin
                        errors++;
                        $display("FAIL write_fields cyc=%0d got=%h exp=%h", neg_cnt,
                                 {mem_write_enable, mem_write_addr, mem_write_data, mem_write_buffer}, e[WR_W-33:0]);
                    end
                end
            end
        end else if (exp_q.size() != 0) begin
            e = exp_q[0];
            if (int'(e[WR_W-1 -: 32]) <= neg_cnt) begin
                checks++; errors++;
                $display("FAIL write_missing cyc=%0d exp=%h", neg_cnt, e[WR_W-33:0]);
                void'(exp_q.pop_front());
            end
        end

        if (frame_done) begin
            checks++;
            if (frm_q.size() == 0 || int'(frm_q[0][FR_W-1 -: 32]) != neg_cnt) begin
                errors++;
                $display("FAIL frame_unexpected cyc=%0d pop=%0d gen=%0d", neg_cnt, population, generation);
            end else begin
                f = frm_q.pop_front();
                if ({population, generation} !== f[PW+GW-1:0]) begin
                    errors++;
                    $display("FAIL frame_values got pop=%0d gen=%0d exp pop=%0d gen=%0d",
                             population, generation, f[PW+GW-1:GW], f[GW-1:0]);
                end
            end
        end else if (frm_q.size() != 0) begin
            f = frm_q[0];
            if (int'(f[FR_W-1 -: 32]) <= neg_cnt) begin
                checks++; errors++;
                $display("FAIL frame_missing cyc=%0d", neg_cnt);
                void'(frm_q.pop_front());
            end
        end

        if (resetn) begin
            checks++;
            if (onehot_error !== (err_exp && neg_cnt >= err_due)) begin
                errors++;
                $display("FAIL onehot_error cyc=%0d got=%0b exp=%0b", neg_cnt, onehot_error,
                         err_exp && neg_cnt >= err_due);
            end
        end
        neg_cnt++;
    end

    // ---------------- stimulus ----------------
    initial begin
        resetn = 1'b0; enable = 1'b0; write_enable_in = 9'h0; read_enable_in = 9'h0;
        write_addr_in = '0; frame_buffer_select_in = 1'b0; read_data = 9'h0;
        model_reset();
        apply_reset();

        // blinker, two generations
        for (int y = 0; y < 6; y++)
            for (int x = 0; x < 6; x++) grid[y][x] = 1'b0;
        grid[2][1] = 1'b1; grid[2][2] = 1'b1; grid[2][3] = 1'b1;
        run_frame(1'b0);
        run_frame(1'b1);
        idle(4);
        check("blinker_pop", 32'(population), 32'd3);
        check("blinker_gen", 32'(generation), 32'd2);

        // random grids
        for (int f = 0; f < 4; f++) begin
            for (int y = 0; y < 6; y++)
                for (int x = 0; x < 6; x++) grid[y][x] = ($urandom_range(0, 2) == 0);
            run_frame(f[0]);
        end

        // directed rule vectors, bubbles and one-hot error
        drive(1'b1, 9'h010, 9'h1FF, 2'd0, 1'b0, 9'h01B, 1'b1);
        drive(1'b1, 9'h010, 9'h1FF, 2'd1, 1'b0, 9'h007, 1'b1);
        bubble();
        bubble();
        drive(1'b1, 9'h010, 9'h1FF, 2'd2, 1'b0, 9'h0FF, 1'b0);
        drive(1'b1, 9'h010, 9'h1F8, 2'd3, 1'b0, 9'h01F, 1'b0);
        drive(1'b1, 9'h000, 9'h1FF, 2'd1, 1'b0, 9'h1FF, 1'b0);
        drive(1'b1, 9'h001, 9'h1FF, 2'd2, 1'b0, 9'h00E, 1'b1);
        drive(1'b1, 9'h003, 9'h1FF, 2'd2, 1'b0, 9'h00E, 1'b0);
        idle(6);
        check("err_sticky", 32'(onehot_error), 32'd1);

        // reset one cycle after an enabled pixel
        drive(1'b1, 9'h010, 9'h1FF, 2'd3, 1'b1, 9'h01B, 1'b1);
        apply_reset();
        idle(4);

        // pipeline restarts cleanly
        for (int y = 0; y < 6; y++)
            for (int x = 0; x < 6; x++) grid[y][x] = ($urandom_range(0, 1) == 0);
        run_frame(1'b0);
        run_frame(1'b1);
        idle(RL + 4);
        check("drain_writes", 32'(exp_q.size()), 32'd0);
        check("drain_frames", 32'(frm_q.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        errors++;
        $display("FAIL timeout");
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
